// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Single-outstanding load/store engine sitting between a request/response
// handshake and a simple synchronous data memory (one-cycle read latency).
// Each accepted request forms an effective address from an unsigned base and
// a signed 4-bit offset. The address is range-checked against MEM_DEPTH. A
// valid request performs one memory write (store) or one memory read (load).
// Every request, faulting or not, ends in exactly one response.
//
// Ports
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   req_valid/ready   : request handshake; ready only while idle
//   req_is_store      : 1 = store, 0 = load
//   req_base          : unsigned base address (DATA_W bits)
//   req_offset        : signed two's-complement offset (4 bits)
//   req_store_data    : value to store
//   mem_addr          : memory address, held between accesses
//   mem_write_enable  : one-cycle write strobe
//   mem_write_data    : memory write value, held between stores
//   mem_read_data     : memory read value, valid one cycle after the address
//   resp_valid/ready  : response handshake
//   resp_data         : load result, store value echoed, or 0 on fault
//   resp_fault        : effective address was outside 0..MEM_DEPTH-1
//   txn_count         : completed responses, wraps modulo 256
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int DATA_W    = 9,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [DATA_W-1:0] req_base,
    input  logic [3:0]        req_offset,
    input  logic [DATA_W-1:0] req_store_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write_enable,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_fault,
    output logic [7:0]        txn_count
);

    // One extra bit so base + offset can never silently wrap into range.
    localparam int EA_W = DATA_W + 1;
    localparam logic [EA_W-1:0] DEPTH_EA = EA_W'(MEM_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        STORE,
        LD_ISSUE,
        LD_WAIT,
        RESP
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   resp_data_q, resp_data_d;
    logic                resp_fault_q, resp_fault_d;
    logic [7:0]          txn_count_q, txn_count_d;

    logic [EA_W-1:0]     ea;
    logic                ea_fault;

    // Zero-extended base plus sign-extended offset.
    assign ea = {1'b0, req_base} + {{(EA_W-4){req_offset[3]}}, req_offset};

    // Viewed as unsigned, a negative result lands at 2^EA_W - 8 or above,
    // and the largest positive sum (base max + 7) stays below 2^EA_W. So one
    // unsigned compare catches both "below zero" and "past the end".
    assign ea_fault = (ea >= DEPTH_EA);

    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_data_d  = resp_data_q;
        resp_fault_d = resp_fault_q;
        txn_count_d  = txn_count_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (ea_fault) begin
                        state_d      = RESP;
                        resp_fault_d = 1'b1;
                        resp_data_d  = '0;
                    end else if (req_is_store) begin
                        state_d     = STORE;
                        mem_addr_d  = ea[ADDR_W-1:0];
                        mem_wdata_d = req_store_data;
                    end else begin
                        state_d    = LD_ISSUE;
                        mem_addr_d = ea[ADDR_W-1:0];
                    end
                end
            end
            STORE: begin
                state_d      = RESP;
                resp_data_d  = mem_wdata_q;
                resp_fault_d = 1'b0;
            end
            LD_ISSUE: begin
                state_d = LD_WAIT;
            end
            LD_WAIT: begin
                // The read issued in LD_ISSUE is on mem_read_data now.
                state_d      = RESP;
                resp_data_d  = mem_read_data;
                resp_fault_d = 1'b0;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d     = IDLE;
                    txn_count_d = txn_count_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_data_q  <= '0;
            resp_fault_q <= 1'b0;
            txn_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_data_q  <= resp_data_d;
            resp_fault_q <= resp_fault_d;
            txn_count_q  <= txn_count_d;
        end
    end

    assign req_ready        = (state_q == IDLE);
    assign mem_write_enable = (state_q == STORE);
    assign resp_valid       = (state_q == RESP);
    assign mem_addr         = mem_addr_q;
    assign mem_write_data   = mem_wdata_q;
    assign resp_data        = resp_data_q;
    assign resp_fault       = resp_fault_q;
    assign txn_count        = txn_count_q;

endmodule
